// File: rtl/radix4_job_sequencer.sv
// Job sequencer around the radix-4 8x8 multiplier: valid/ready in/out, MAC accumulator.
// Ports: clock/reset, in_* stream, mul_* multiplier pins, out_* stream, acc_*, op_count, err.
// Optional macro RADIX4_SEQ_TIMEOUT_EN bounds WAIT to TIMEOUT_CYC cycles and pulses err.
module radix4_job_sequencer #(
  parameter int ACC_W       = 24,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_x,
  input  logic [7:0]       in_y,
  output logic             mul_reset,
  output logic             mul_start,
  output logic [7:0]       mul_x,
  output logic [7:0]       mul_y,
  input  logic             mul_ready,
  input  logic [15:0]      mul_product,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_product,
  input  logic             acc_clear,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_ovf,
  output logic [7:0]       op_count,
  output logic             err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  logic [2:0]     state;
  logic           cap;
  logic           tmo;
  logic [ACC_W:0] acc_sum;

  assign cap = (state == S_WAIT) && mul_ready;

`ifdef RADIX4_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (state != S_WAIT) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Fires on the TIMEOUT_CYC-th WAIT cycle without a done.
  assign tmo = (state == S_WAIT) && !mul_ready &&
               (tmo_cnt == TW'(TIMEOUT_CYC - 1));
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      in_ready    <= 1'b1;
      mul_reset   <= 1'b1;
      mul_start   <= 1'b0;
      mul_x       <= '0;
      mul_y       <= '0;
      out_valid   <= 1'b0;
      out_product <= '0;
      err         <= 1'b0;
    end else begin
      err <= tmo;
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            mul_x    <= in_x;
            mul_y    <= in_y;
            in_ready <= 1'b0;
            state    <= S_CLR;
          end
        end
        S_CLR: begin
          mul_reset <= 1'b0;
          mul_start <= 1'b1;
          state     <= S_START;
        end
        S_START: begin
          mul_start <= 1'b0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          if (cap) begin
            out_product <= mul_product;
            out_valid   <= 1'b1;
            mul_reset   <= 1'b1;
            state       <= S_OUT;
          end else if (tmo) begin
            out_product <= '0;
            out_valid   <= 1'b1;
            mul_reset   <= 1'b1;
            state       <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          mul_reset <= 1'b1;
          mul_start <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Extra top bit is the carry that marks a wrap.
  assign acc_sum = {1'b0, acc_out} + (ACC_W+1)'(mul_product);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_out  <= '0;
      acc_ovf  <= 1'b0;
      op_count <= '0;
    end else begin
      // Clear wins over the old value but not over a same-cycle product.
      if (acc_clear) begin
        acc_out <= cap ? ACC_W'(mul_product) : '0;
        acc_ovf <= 1'b0;
      end else if (cap) begin
        acc_out <= acc_sum[ACC_W-1:0];
        acc_ovf <= acc_ovf | acc_sum[ACC_W];
      end
      if (cap) begin
        op_count <= op_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_radix4_job_sequencer.sv
// Directed + random bench for radix4_job_sequencer with a behavioural multiplier stub.
// Reference model: plain-arithmetic products, accumulator sum/wrap and job counter.
module tb_radix4_job_sequencer;

  localparam int ACCW = 16;
  localparam int AMOD = 1 << ACCW;

  logic            clock = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [7:0]      in_x;
  logic [7:0]      in_y;
  logic            mul_reset;
  logic            mul_start;
  logic [7:0]      mul_x;
  logic [7:0]      mul_y;
  logic            mul_ready;
  logic [15:0]     mul_product;
  logic            out_valid;
  logic            out_ready;
  logic [15:0]     out_product;
  logic            acc_clear;
  logic [ACCW-1:0] acc_out;
  logic            acc_ovf;
  logic [7:0]      op_count;
  logic            err;

  int vectors    = 0;
  int miscompares = 0;

  int unsigned m_acc;
  bit          m_ovf;
  int unsigned m_cnt;

  int   mlat = 3;
  logic hang = 1'b0;
  logic busy;
  int   mcnt;

  always #5 clock = ~clock;

  radix4_job_sequencer #(.ACC_W(ACCW), .TIMEOUT_CYC(64)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y),
    .mul_reset(mul_reset), .mul_start(mul_start),
    .mul_x(mul_x), .mul_y(mul_y),
    .mul_ready(mul_ready), .mul_product(mul_product),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product),
    .acc_clear(acc_clear), .acc_out(acc_out), .acc_ovf(acc_ovf),
    .op_count(op_count), .err(err)
  );

  // Multiplier stub: done mlat cycles after start, level until mul_reset.
  always @(posedge clock) begin
    if (mul_reset) begin
      mul_ready   <= 1'b0;
      mul_product <= 16'h0;
      busy        <= 1'b0;
      mcnt        <= 0;
    end else if (mul_start) begin
      busy <= 1'b1;
      mcnt <= mlat;
    end else if (busy && !hang) begin
      if (mcnt <= 1) begin
        mul_ready   <= 1'b1;
        mul_product <= 16'(mul_x * mul_y);
        busy        <= 1'b0;
      end else begin
        mcnt <= mcnt - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = 0;
    m_ovf = 0;
    m_cnt = 0;
  endtask

  task automatic accept(input logic [7:0] x, input logic [7:0] y);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_x     = x;
    in_y     = y;
    @(negedge clock);
    in_valid = 1'b0;
    in_x     = 8'($urandom);
    in_y     = 8'($urandom);
    chk("in_ready_busy", in_ready, 0);
    chk("mul_reset_clr", mul_reset, 1);
  endtask

  task automatic run_job(input logic [7:0] x, input logic [7:0] y,
                         input int lat, input int bp, input bit clr_cap);
    int          n;
    int unsigned p;
    int unsigned s;
    mlat = lat;
    accept(x, y);
    n = 0;
    while (!out_valid && n < 300) begin
      if (mul_start) begin
        chk("mul_x", mul_x, x);
        chk("mul_y", mul_y, y);
        chk("mul_reset_start", mul_reset, 0);
      end
      acc_clear = clr_cap && mul_ready;
      @(negedge clock);
      n++;
      if (!out_valid) chk("in_ready_wait", in_ready, 0);
    end
    acc_clear = 1'b0;
    chk("out_valid_arrive", out_valid, 1);
    p = int'(x) * int'(y);
    if (clr_cap) begin
      m_acc = p;
      m_ovf = 0;
    end else begin
      s = m_acc + p;
      if (s >= AMOD) m_ovf = 1;
      m_acc = s % AMOD;
    end
    m_cnt = (m_cnt + 1) % 256;
    chk("out_product", out_product, p);
    chk("acc_out", acc_out, m_acc);
    chk("acc_ovf", acc_ovf, m_ovf);
    chk("op_count", op_count, m_cnt);
    for (int i = 0; i < bp; i++) begin
      @(negedge clock);
      chk("bp_valid", out_valid, 1);
      chk("bp_product", out_product, p);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    chk("post_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
  endtask

  initial begin
    int n;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_x      = 8'h0;
    in_y      = 8'h0;
    out_ready = 1'b0;
    acc_clear = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_mul_reset", mul_reset, 1);
    chk("rst_mul_start", mul_start, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_acc", acc_out, 0);
    chk("rst_cnt", op_count, 0);
    chk("rst_err", err, 0);
    reset = 1'b0;
    @(negedge clock);

    run_job(8'd13, 8'd11, 4, 0, 0);
    run_job(8'd255, 8'd255, 2, 1, 0);
    run_job(8'd0, 8'd200, 1, 0, 0);
    run_job(8'd17, 8'd29, 5, 20, 0);

    acc_clear = 1'b1;
    @(negedge clock);
    acc_clear = 1'b0;
    m_acc = 0;
    m_ovf = 0;
    chk("clr_acc", acc_out, 0);
    chk("clr_ovf", acc_ovf, 0);

    run_job(8'd255, 8'd255, 3, 0, 0);
    run_job(8'd255, 8'd255, 3, 0, 0);
    chk("wrap_acc", acc_out, 64514);
    chk("wrap_ovf", acc_ovf, 1);
    run_job(8'd3, 8'd4, 3, 0, 1);

    for (int k = 0; k < 20; k++) begin
      run_job(8'($urandom), 8'($urandom), int'($urandom_range(1, 8)),
              int'($urandom_range(0, 3)), 0);
    end

    mlat = 40;
    accept(8'd9, 8'd9);
    repeat (6) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("mid_in_ready", in_ready, 1);
    chk("mid_mul_reset", mul_reset, 1);
    chk("mid_mul_start", mul_start, 0);
    chk("mid_mul_x", mul_x, 0);
    chk("mid_mul_y", mul_y, 0);
    chk("mid_out_valid", out_valid, 0);
    chk("mid_out_product", out_product, 0);
    chk("mid_acc", acc_out, 0);
    chk("mid_ovf", acc_ovf, 0);
    chk("mid_cnt", op_count, 0);
    chk("mid_err", err, 0);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    @(negedge clock);
    run_job(8'd7, 8'd9, 3, 0, 0);
    chk("after_rst_cnt", op_count, 1);

    hang = 1'b1;
    accept(8'd5, 8'd5);
`ifdef RADIX4_SEQ_TIMEOUT_EN
    n = 0;
    while (!err && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("tmo_latency", n, 66);
    chk("tmo_valid", out_valid, 1);
    chk("tmo_product", out_product, 0);
    chk("tmo_cnt", op_count, m_cnt);
    chk("tmo_acc", acc_out, m_acc);
    @(negedge clock);
    chk("tmo_pulse", err, 0);
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    chk("tmo_in_ready", in_ready, 1);
`else
    repeat (100) @(negedge clock);
    chk("hang_valid", out_valid, 0);
    chk("hang_in_ready", in_ready, 0);
    chk("hang_err", err, 0);
    chk("hang_cnt", op_count, m_cnt);
`endif
    hang = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    @(negedge clock);
    run_job(8'd6, 8'd7, 2, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
